// File: rtl/lsu_mem_stage_if.sv
// Bundle of EX-side inputs, data-memory bus and writeback packet for the
// load/store stage. master = the stage itself, slave = its surroundings.
interface lsu_mem_stage_if;
    // EX stage handoff
    logic        ex_valid;
    logic        ex_ready;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic        reg_write;
    // data memory
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    // writeback
    logic        wb_valid;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_exc;
    logic [3:0]  wb_cause;

    modport master (
        input  ex_valid, mem_read, mem_write, funct3, alu_result, store_data,
               rd, reg_write, dmem_ack, dmem_rdata,
        output ex_ready, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
               wb_valid, wb_we, wb_rd, wb_data, wb_exc, wb_cause
    );

    modport slave (
        output ex_valid, mem_read, mem_write, funct3, alu_result, store_data,
               rd, reg_write, dmem_ack, dmem_rdata,
        input  ex_ready, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
               wb_valid, wb_we, wb_rd, wb_data, wb_exc, wb_cause
    );
endinterface

// File: rtl/lsu_mem_stage.sv
// Load/store stage: one req/ack data-memory transaction per memory op,
// load lane extraction/extension, single-cycle writeback packet with
// illegal / misaligned / access-fault exceptions.
module lsu_mem_stage #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input logic            clk,
    input logic            rst_n,
    lsu_mem_stage_if.master bus
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t     state;
    logic [7:0] tmo_cnt;
    logic [1:0] lane_q;
    logic [2:0] f3_q;
    logic       is_load_q;
    logic       rw_q;

    // decode of the instruction currently presented by EX
    logic        is_mem, f3_ok, misal;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;

    // Stage only takes a new instruction while no memory op is outstanding.
    assign bus.ex_ready = (state == IDLE);

    // Legality, alignment and store lane placement of the incoming op.
    always_comb begin
        is_mem   = bus.mem_read | bus.mem_write;
        f3_ok    = 1'b0;
        misal    = 1'b0;
        st_be    = 4'b1111;
        st_wdata = bus.store_data;
        case (bus.funct3)
            3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
            3'b100, 3'b101:         f3_ok = bus.mem_read;
            default:                f3_ok = 1'b0;
        endcase
        if (bus.mem_read && bus.mem_write) f3_ok = 1'b0;
        if (bus.funct3[1:0] == 2'b01) misal = bus.alu_result[0];
        if (bus.funct3[1:0] == 2'b10) misal = |bus.alu_result[1:0];
        if (bus.mem_write) begin
            case (bus.funct3[1:0])
                2'b00: begin
                    st_be    = 4'b0001 << bus.alu_result[1:0];
                    st_wdata = {4{bus.store_data[7:0]}};
                end
                2'b01: begin
                    st_be    = bus.alu_result[1] ? 4'b1100 : 4'b0011;
                    st_wdata = {2{bus.store_data[15:0]}};
                end
                default: ;
            endcase
        end
    end

    // Pick the addressed lane out of the read word and extend it.
    function automatic logic [31:0] load_ext(input logic [31:0] w,
                                             input logic [1:0]  lane,
                                             input logic [2:0]  f3);
        logic [31:0] s;
        s = w >> {lane, 3'b000};
        case (f3)
            3'b000:  load_ext = {{24{s[7]}}, s[7:0]};
            3'b001:  load_ext = {{16{s[15]}}, s[15:0]};
            3'b100:  load_ext = {24'h0, s[7:0]};
            3'b101:  load_ext = {16'h0, s[15:0]};
            default: load_ext = w;
        endcase
    endfunction

    // Control FSM with registered memory-bus and writeback outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            tmo_cnt        <= '0;
            lane_q         <= '0;
            f3_q           <= '0;
            is_load_q      <= 1'b0;
            rw_q           <= 1'b0;
            bus.dmem_req   <= 1'b0;
            bus.dmem_we    <= 1'b0;
            bus.dmem_addr  <= '0;
            bus.dmem_be    <= '0;
            bus.dmem_wdata <= '0;
            bus.wb_valid   <= 1'b0;
            bus.wb_we      <= 1'b0;
            bus.wb_rd      <= '0;
            bus.wb_data    <= '0;
            bus.wb_exc     <= 1'b0;
            bus.wb_cause   <= '0;
        end else begin
            bus.wb_valid <= 1'b0;
            case (state)
                IDLE: if (bus.ex_valid) begin
                    bus.wb_rd <= bus.rd;
                    lane_q    <= bus.alu_result[1:0];
                    f3_q      <= bus.funct3;
                    is_load_q <= bus.mem_read;
                    rw_q      <= bus.reg_write;
                    if (!is_mem) begin
                        bus.wb_valid <= 1'b1;
                        bus.wb_we    <= bus.reg_write;
                        bus.wb_data  <= bus.alu_result;
                        bus.wb_exc   <= 1'b0;
                        bus.wb_cause <= 4'd0;
                    end else if (!f3_ok || misal) begin
                        bus.wb_valid <= 1'b1;
                        bus.wb_we    <= 1'b0;
                        bus.wb_data  <= '0;
                        bus.wb_exc   <= 1'b1;
                        bus.wb_cause <= !f3_ok ? 4'd2 : (bus.mem_read ? 4'd4 : 4'd6);
                    end else begin
                        state          <= WAIT;
                        tmo_cnt        <= '0;
                        bus.dmem_req   <= 1'b1;
                        bus.dmem_we    <= bus.mem_write;
                        bus.dmem_addr  <= {bus.alu_result[31:2], 2'b00};
                        bus.dmem_be    <= st_be;
                        bus.dmem_wdata <= bus.mem_write ? st_wdata : '0;
                    end
                end
                WAIT: begin
                    // ack beats a timeout landing on the same cycle
                    if (bus.dmem_ack) begin
                        state        <= RESP;
                        bus.dmem_req <= 1'b0;
                        bus.wb_valid <= 1'b1;
                        bus.wb_we    <= is_load_q & rw_q;
                        bus.wb_data  <= is_load_q ? load_ext(bus.dmem_rdata, lane_q, f3_q) : '0;
                        bus.wb_exc   <= 1'b0;
                        bus.wb_cause <= 4'd0;
                    end else if (tmo_cnt == 8'(TIMEOUT_CYCLES - 1)) begin
                        state        <= RESP;
                        tmo_cnt      <= '0;
                        bus.dmem_req <= 1'b0;
                        bus.wb_valid <= 1'b1;
                        bus.wb_we    <= 1'b0;
                        bus.wb_data  <= '0;
                        bus.wb_exc   <= 1'b1;
                        bus.wb_cause <= is_load_q ? 4'd5 : 4'd7;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
Load/store stage directly downstream of the ALU. It consumes the ALU result as the effective address, or as a pass-through value for non-memory instructions. It performs one data-memory transaction with a req/ack handshake, then aligns and extends load data. It presents a single-cycle writeback packet and raises misaligned, illegal and access-fault exceptions.

Parameters:
TIMEOUT_CYCLES, 15, cycles dmem_req may stay high without dmem_ack before an access fault is reported (1..255)

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  synchronous, active-low reset
ex_valid  input  1  EX stage presents an instruction
ex_ready  output  1  stage can accept; high iff FSM in IDLE
mem_read  input  1  instruction is a load
mem_write  input  1  instruction is a store (mem_read&mem_write both high = illegal)
funct3  input  3  RISC-V load/store width/sign code
alu_result  input  32  effective address, or writeback value for non-memory ops
store_data  input  32  rs2 value
rd  input  5  destination register
reg_write  input  1  instruction writes rd
dmem_req  output  1  memory request, held until ack or timeout
dmem_we  output  1  1 = write
dmem_addr  output  32  word-aligned address {alu_result[31:2],2'b00}
dmem_be  output  4  byte enables
dmem_wdata  output  32  lane-replicated store data
dmem_ack  input  1  memory completes request this cycle
dmem_rdata  input  32  read word, valid with dmem_ack on loads
wb_valid  output  1  one-cycle writeback pulse
wb_we  output  1  write rd (0 for stores and exceptions)
wb_rd  output  5  destination register
wb_data  output  32  writeback value
wb_exc  output  1  exception flag, qualified by wb_valid
wb_cause  output  4  RISC-V mcause code, qualified by wb_exc

Behaviour:
- Reset (rst_n low at edge): state IDLE, dmem_req=0, wb_valid=0, wb_exc=0, wb_we=0, timeout counter=0, all data outputs 0; a pending ack is discarded. ex_ready=1 after the reset edge.
- FSM states: IDLE, WAIT, RESP.
- Accept when ex_valid & ex_ready at edge T; all inputs are captured into registers at T.
- Non-memory op (mem_read=mem_write=0):
  - wb_valid=1 at T+1, wb_data=alu_result, wb_we=reg_write.
  - Stays in IDLE, so back-to-back accepts every cycle are allowed.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other code, or mem_read&mem_write both high: wb at T+1 with wb_exc=1, cause 2, no memory request.
- Misaligned (half with addr[0]=1; word with addr[1:0]!=0): wb at T+1 with wb_exc=1, wb_we=0, cause 4 for loads or 6 for stores; no request.
- Aligned memory op: state WAIT from T+1.
  - dmem_req=1 at T+1.
  - dmem_addr, dmem_we, dmem_be and dmem_wdata are registered and stable while req is high.
- Store lanes:
  - SB: be=4'b0001<<addr[1:0], wdata={4{d[7:0]}}.
  - SH: be=addr[1]?4'b1100:4'b0011, wdata={2{d[15:0]}}.
  - SW: be=4'b1111, wdata=d.
  - Loads: be=4'b1111, dmem_we=0.
- Ack:
  - dmem_ack sampled high while in WAIT drops dmem_req at the next edge and enters RESP.
  - RESP drives wb_valid=1 for one cycle, then returns to IDLE.
  - Earliest wb_valid is T+2 (ack at T+1); ex_ready is high again one cycle after RESP.
- Load extract: lane selected by addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - wb_we=reg_write for loads, 0 for stores.
- Timeout:
  - Counter increments each WAIT cycle without ack.
  - After TIMEOUT_CYCLES request cycles with no ack: drop req and enter RESP with wb_exc=1, wb_we=0, cause 5 (load) or 7 (store).
  - If ack and timeout occur in the same cycle, ack wins.
  - Counter clears on entry to WAIT.
- dmem_ack outside WAIT is ignored.
- ex_valid outside IDLE is not accepted; EX must hold its inputs.
- wb_rd always equals the captured rd.

Test Plan:
- SW alu_result=0x100, store_data=0xDEADBEEF, ack 2 cycles after req -> dmem_addr=0x100, be=1111, wdata=0xDEADBEEF, req high exactly 2 cycles, wb_valid with wb_we=0, wb_exc=0.
- LB at 0x103 with rdata=0x80112233 -> wb_data=0xFFFFFF80; LBU same address -> 0x00000080; LH at 0x102 -> 0xFFFF8011.
- SH at 0x102, store_data=0x1234ABCD -> dmem_addr=0x100, be=1100, wdata=0xABCDABCD.
- LW at 0x102 -> no dmem_req, wb_valid at T+1, wb_exc=1, cause 4; funct3=011 load -> cause 2.
- LW with no ack, TIMEOUT_CYCLES=15 -> req high 15 cycles then low, wb_exc=1, cause 5, ex_ready low throughout; repeat with ack on the 15th cycle -> normal load, no exception.
- Three back-to-back non-memory ops (0x55 rd=7, 0x66 rd=8, 0x77 rd=9, reg_write=1) -> wb_valid on three consecutive cycles with matching data and rd; rst_n low while in WAIT -> req=0 and wb_valid=0 after the edge, and a later ack is ignored.
